// File: rtl/arbitro_memoria_datos.sv
// Two-master data-memory arbiter: round-robin on ties, one strobe per access, region decode, ROM/misalignment rejection.
// gnt one cycle after req is seen in INACTIVO; fin 2 cycles after (2+LAT_LECTURA for reads); req is held by the master until gnt.
module arbitro_memoria_datos #(
    parameter int LAT_LECTURA = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] dir0,
    input  logic [31:0] dir1,
    input  logic [31:0] din0,
    input  logic [31:0] din1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        fin0,
    output logic        fin1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] dout,
    output logic        mem_EscrMem,
    output logic        mem_LeerMem,
    output logic [31:0] mem_Direc,
    output logic [31:0] mem_Datain,
    input  logic [31:0] mem_Dataout,
    output logic        CSram1,
    output logic        CSram2,
    output logic        CSrom
);

    localparam logic [1:0] INACTIVO = 2'd0;
    localparam logic [1:0] ACCESO   = 2'd1;
    localparam logic [1:0] ESPERA   = 2'd2;
    localparam logic [1:0] FIN      = 2'd3;

    localparam logic [1:0] C_ULTIMO = 2'(LAT_LECTURA - 1);

    logic [1:0]  r_estado;
    logic        r_ultimo;
    logic        r_id;
    logic        r_we;
    logic [31:0] r_dir;
    logic [31:0] r_din;
    logic [1:0]  r_cnt;
    logic [31:0] r_dout;

    logic w_gana1;
    logic w_ram1;
    logic w_ram2;
    logic w_rom;
    logic w_err;
    logic w_sel;

    // On a tie the requester that was not served last wins.
    assign w_gana1 = req1 & (~req0 | ~r_ultimo);

    assign w_ram1 = (r_dir[31:8] == 24'hFFFFFF);
    assign w_ram2 = (r_dir[31:8] == 24'hFFFFFE);
    assign w_rom  = ~w_ram1 & ~w_ram2;
    assign w_err  = (r_we & w_rom) | (r_dir[1:0] != 2'b00);
    assign w_sel  = (r_estado == ACCESO) | (r_estado == ESPERA);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= INACTIVO;
            r_ultimo <= 1'b1;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_dir    <= 32'h0;
            r_din    <= 32'h0;
            r_cnt    <= 2'd0;
            r_dout   <= 32'h0;
        end else begin
            case (r_estado)
                INACTIVO: begin
                    if (req0 | req1) begin
                        r_id     <= w_gana1;
                        r_ultimo <= w_gana1;
                        r_we     <= w_gana1 ? we1  : we0;
                        r_dir    <= w_gana1 ? dir1 : dir0;
                        r_din    <= w_gana1 ? din1 : din0;
                        r_estado <= ACCESO;
                    end
                end
                ACCESO: begin
                    r_cnt    <= 2'd0;
                    r_estado <= (~r_we & ~w_err) ? ESPERA : FIN;
                end
                ESPERA: begin
                    if (r_cnt == C_ULTIMO) begin
                        r_dout   <= mem_Dataout;
                        r_estado <= FIN;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: r_estado <= INACTIVO;
            endcase
        end
    end

    assign gnt0        = (r_estado == ACCESO) & ~r_id;
    assign gnt1        = (r_estado == ACCESO) &  r_id;
    assign fin0        = (r_estado == FIN) & ~r_id;
    assign fin1        = (r_estado == FIN) &  r_id;
    assign err0        = fin0 & w_err;
    assign err1        = fin1 & w_err;
    assign mem_EscrMem = (r_estado == ACCESO) & ~w_err &  r_we;
    assign mem_LeerMem = (r_estado == ACCESO) & ~w_err & ~r_we;
    assign CSram1      = w_sel & w_ram1;
    assign CSram2      = w_sel & w_ram2;
    assign CSrom       = w_sel & w_rom;
    assign mem_Direc   = r_dir;
    assign mem_Datain  = r_din;
    assign dout        = r_dout;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed bench for arbitro_memoria_datos with a two-cycle read-latency memory model.
module tb_arbitro_memoria_datos;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] dir0, dir1, din0, din1;
    logic        gnt0, gnt1, fin0, fin1, err0, err1;
    logic [31:0] dout, mem_Direc, mem_Datain, mem_Dataout;
    logic        mem_EscrMem, mem_LeerMem, CSram1, CSram2, CSrom;

    logic [31:0] rd_val;
    logic [31:0] r_d1, r_d2;
    logic [10:0] ctl;

    int ntot  = 0;
    int npass = 0;
    int nfail = 0;

    localparam logic [10:0] G0 = 11'h400, G1 = 11'h200, F0 = 11'h100, F1 = 11'h080;
    localparam logic [10:0] E0 = 11'h040, E1 = 11'h020, WR = 11'h010, RD = 11'h008;
    localparam logic [10:0] R1 = 11'h004, R2 = 11'h002, RO = 11'h001, NADA = 11'h000;

    arbitro_memoria_datos #(.LAT_LECTURA(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .dir0(dir0), .dir1(dir1), .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .fin0(fin0), .fin1(fin1),
        .err0(err0), .err1(err1), .dout(dout),
        .mem_EscrMem(mem_EscrMem), .mem_LeerMem(mem_LeerMem),
        .mem_Direc(mem_Direc), .mem_Datain(mem_Datain), .mem_Dataout(mem_Dataout),
        .CSram1(CSram1), .CSram2(CSram2), .CSrom(CSrom)
    );

    always #5 clk = ~clk;

    // Memory returns the read word two cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
        r_d1 <= mem_LeerMem ? rd_val : 32'hDEADBEEF;
        r_d2 <= r_d1;
    end
    assign mem_Dataout = r_d2;

    assign ctl = {gnt0, gnt1, fin0, fin1, err0, err1, mem_EscrMem, mem_LeerMem, CSram1, CSram2, CSrom};

    task automatic ciclo();
        @(negedge clk);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [10:0] exp);
        ntot++;
        assert (ctl === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: ctl observed %b expected %b", tag, ctl, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        dir0 = 32'h0; dir1 = 32'h0; din0 = 32'h0; din1 = 32'h0;
        rd_val = 32'h0;
        ciclo();
        ciclo();
        chkc("rst_ctl", NADA);
        chk32("rst_dout", dout, 32'h0);
        chk32("rst_direc", mem_Direc, 32'h0);
        chk32("rst_datain", mem_Datain, 32'h0);
        reset = 1'b0;
        ciclo();

        // Write to RAM1 from requester 0
        req0 = 1'b1; we0 = 1'b1; dir0 = 32'hFFFFFF10; din0 = 32'hA5A5A5A5;
        ciclo();
        chkc("wr_gnt", G0 | WR | R1);
        chk32("wr_direc", mem_Direc, 32'hFFFFFF10);
        chk32("wr_datain", mem_Datain, 32'hA5A5A5A5);
        req0 = 1'b0;
        ciclo();
        chkc("wr_fin", F0);
        chk32("wr_dout", dout, 32'h0);
        ciclo();
        chkc("wr_idle", NADA);

        // Read from RAM2 by requester 1
        req1 = 1'b1; we1 = 1'b0; dir1 = 32'hFFFFFE04; rd_val = 32'h12345678;
        ciclo();
        chkc("rd_gnt", G1 | RD | R2);
        req1 = 1'b0;
        ciclo();
        chkc("rd_wait1", R2);
        chk32("rd_direc", mem_Direc, 32'hFFFFFE04);
        ciclo();
        chkc("rd_wait2", R2);
        ciclo();
        chkc("rd_fin", F1);
        chk32("rd_dout", dout, 32'h12345678);
        ciclo();
        chkc("rd_idle", NADA);

        // Write to ROM: rejected
        req0 = 1'b1; we0 = 1'b1; dir0 = 32'h00000020; din0 = 32'h11111111;
        ciclo();
        chkc("erom_gnt", G0 | RO);
        req0 = 1'b0;
        ciclo();
        chkc("erom_fin", F0 | E0);
        chk32("erom_dout", dout, 32'h12345678);
        // Misaligned read: rejected
        req1 = 1'b1; we1 = 1'b0; dir1 = 32'hFFFFFF02;
        ciclo();
        ciclo();
        chkc("emis_gnt", G1 | R1);
        req1 = 1'b0;
        ciclo();
        chkc("emis_fin", F1 | E1);
        chk32("emis_dout", dout, 32'h12345678);
        ciclo();
        chkc("emis_idle", NADA);

        // Tie: both held for four write transactions, last served was 1
        req0 = 1'b1; we0 = 1'b1; dir0 = 32'hFFFFFF20; din0 = 32'h0000AAAA;
        req1 = 1'b1; we1 = 1'b1; dir1 = 32'hFFFFFE08; din1 = 32'h0000BBBB;
        for (int t = 0; t < 4; t++) begin
            ciclo();
            chkc($sformatf("tie%0d_gnt", t), (t % 2 == 0) ? (G0 | WR | R1) : (G1 | WR | R2));
            chk32($sformatf("tie%0d_datain", t), mem_Datain, (t % 2 == 0) ? 32'h0000AAAA : 32'h0000BBBB);
            ciclo();
            chkc($sformatf("tie%0d_fin", t), (t % 2 == 0) ? F0 : F1);
            if (t == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            ciclo();
            chkc($sformatf("tie%0d_idle", t), NADA);
        end
        ciclo();
        chkc("tie_quiet", NADA);

        // Reset during ESPERA of a read
        req0 = 1'b1; we0 = 1'b0; dir0 = 32'hFFFFFF04; rd_val = 32'hCAFEF00D;
        ciclo();
        chkc("rsw_gnt", G0 | RD | R1);
        req0 = 1'b0;
        ciclo();
        chkc("rsw_wait", R1);
        reset = 1'b1;
        ciclo();
        chkc("rsw_ctl", NADA);
        chk32("rsw_dout", dout, 32'h0);
        chk32("rsw_direc", mem_Direc, 32'h0);
        chk32("rsw_datain", mem_Datain, 32'h0);
        reset = 1'b0;
        ciclo();
        chkc("rsw_nofin", NADA);
        ciclo();
        chkc("rsw_nofin2", NADA);

        // Normal read after reset
        req1 = 1'b1; we1 = 1'b0; dir1 = 32'hFFFFFE0C; rd_val = 32'h0BADCAFE;
        ciclo();
        chkc("post_gnt", G1 | RD | R2);
        req1 = 1'b0;
        ciclo();
        chkc("post_wait1", R2);
        ciclo();
        chkc("post_wait2", R2);
        ciclo();
        chkc("post_fin", F1);
        chk32("post_dout", dout, 32'h0BADCAFE);
        ciclo();
        chkc("post_idle", NADA);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_datos.md
# arbitro_memoria_datos

Two-master arbiter and access sequencer for the data memory of the single-cycle processor. It shares one data-memory port between the CPU data path (requester 0) and a secondary master such as a loader or debug port (requester 1). Each accepted request is turned into a single-cycle, chip-selected memory strobe, and the read data is returned through a registered response handshake. Writes to the ROM region and misaligned accesses are blocked and flagged.

## Interface
- `LAT_LECTURA`, 1: memory read latency in cycles, from the `mem_LeerMem` strobe to valid `mem_Dataout`. Legal values are 1..3.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  request; held by the requester until its `gnt` is seen.
- `we0` / `we1`  in  1  1 = write, 0 = read; sampled at grant.
- `dir0` / `dir1`  in  32  byte address; sampled at grant.
- `din0` / `din1`  in  32  write data; sampled at grant.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request accepted.
- `fin0` / `fin1`  out  1  one-cycle pulse: transaction complete.
- `err0` / `err1`  out  1  valid with `fin`; the access was rejected.
- `dout`  out  32  read data, valid while `fin0` or `fin1` is high.
- `mem_EscrMem`, `mem_LeerMem`  out  1  memory strobes.
- `mem_Direc`, `mem_Datain`  out  32  latched address and write data.
- `mem_Dataout`  in  32  memory read data.
- `CSram1`, `CSram2`, `CSrom`  out  1  one-hot region selects.

## Operation
- **States:** INACTIVO, ACCESO, ESPERA, FIN. Reset state is INACTIVO.
- **INACTIVO:**
  - If neither request is high, stay in INACTIVO.
  - If exactly one request is high, that requester wins.
  - If both are high, the winner is the requester not served last. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - On a win: latch `we`, `dir` and `din` of the winner plus its id, update the pointer, and go to ACCESO.
- **Region decode** of the latched address:
  - `dir[31:8] == 24'hFFFFFF` selects `CSram1`.
  - `dir[31:8] == 24'hFFFFFE` selects `CSram2`.
  - Any other value selects `CSrom`.
- **Errors:** an access is in error if it is a write with `CSrom` selected, or if `dir[1:0] != 0`.
- **ACCESO** (exactly 1 cycle):
  - `gnt` of the winner is high.
  - `mem_Direc` and `mem_Datain` carry the latched values.
  - The region select is high.
  - If there is no error, `mem_EscrMem = we` and `mem_LeerMem = !we`. If there is an error, both strobes are 0.
  - Next state: ESPERA for an error-free read, otherwise FIN.
- **ESPERA:**
  - Lasts `LAT_LECTURA` cycles, counted by a 2-bit counter.
  - The region select and `mem_Direc` stay held; strobes are 0.
  - On the last cycle, `mem_Dataout` is captured into `dout`.
  - Next state: FIN.
- **FIN** (1 cycle):
  - `fin` of the served requester is high.
  - `err` is high if the access was rejected.
  - `dout` holds the captured data. For writes and errors, `dout` keeps its previous value.
  - Next state: INACTIVO. A `req` sampled in FIN is ignored and is considered again in INACTIVO.
- **Outputs outside these states:** all strobes, selects, `gnt`, `fin` and `err` are 0 whenever the state does not drive them.
- **Requester rules:**
  - A requester may drop `req` after `gnt`.
  - If `req` is still high at INACTIVO, it is treated as a new request.
  - A `req` that drops before `gnt` is withdrawn without side effects.

## Timing
- **Reset:**
  - Every output is 0, including `dout`, `mem_Direc` and `mem_Datain`.
  - The pointer is 1 and the state is INACTIVO.
- **Reset mid-transaction:** in the next cycle the outputs are already at their reset values. No `fin` is issued and the transaction is lost.
- **Latency with `req` first seen high in INACTIVO during cycle N:**
  - `gnt` is in cycle N+1.
  - For a write or an error, `fin` is in cycle N+2.
  - For a read, `fin` is in cycle N+2+`LAT_LECTURA`.
- **Throughput:** a write or error takes 3 cycles per transaction; a read takes 3+`LAT_LECTURA`. The state returns to INACTIVO between every pair of transactions.
- **Back-to-back with both requests held:** grants alternate 0, 1, 0, 1, …
- **Strobes:** each accepted error-free access produces exactly one strobe cycle, and only in ACCESO.
- **Selects:** exactly one select is high during ACCESO and ESPERA.

## Test plan
- **Reset:**
  - Stimulus: after reset, raise `req0` with `we0=1`, `dir0=32'hFFFFFF10`, `din0=32'hA5A5A5A5`.
  - Response: `gnt0` in cycle 1, with `mem_EscrMem=1` and `CSram1=1`. `fin0` in cycle 2 with `err0=0`.
- **Read:**
  - Stimulus: `LAT_LECTURA=2`, `req1` read at `32'hFFFFFE04`, memory model returns `32'h12345678`.
  - Response: `CSram2=1` for 3 cycles. `fin1` at N+4 with `dout=32'h12345678`.
- **Tie:**
  - Stimulus: `req0` and `req1` both held high for 4 transactions.
  - Response: grant order 0, 1, 0, 1, with no strobe overlap.
- **Errors:**
  - Stimulus: write to `32'h00000020`, then a read from `32'hFFFFFF02`.
  - Response: both give `err=1` at N+2 with no memory strobe. `dout` is unchanged.
- **Reset during ESPERA:**
  - Stimulus: assert `reset` during ESPERA of a read.
  - Response: no `fin` is issued and the next cycle has all outputs 0. A subsequent request completes normally.
